// File: rtl/multi_rate_en_gen_pkg.sv
// Shared constants for the multi-rate enable generator: core clock rate,
// the default 8 MHz divisor and the parameter limits.
package multi_rate_en_gen_pkg;

    localparam int CORE_CLK_HZ = 200_000_000;
    localparam int DIV_8MHZ    = 25;
    localparam int MAX_NCH     = 16;
    localparam int MAX_CW      = 16;

    // Width of a channel-select field; never narrower than one bit.
    function automatic int ch_sel_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/multi_rate_en_gen_channel.sv
// One enable channel: free-running divider counter, active and shadow
// divisor/phase, pending flag and phase compare. Optional count tap under
// MULTI_RATE_EN_GEN_DBG_COUNT_EN.
module en_gen_channel
    import multi_rate_en_gen_pkg::*;
#(
    parameter int CW      = 8,
    parameter int DEF_DIV = DIV_8MHZ
) (
`ifdef MULTI_RATE_EN_GEN_DBG_COUNT_EN
    output logic [CW-1:0] o_dbg_cnt,
`endif
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_en,
    input  logic          i_load,
    input  logic          i_wr,
    input  logic [CW-1:0] i_wr_div,
    input  logic [CW-1:0] i_wr_phase,
    output logic          o_pending,
    output logic          o_en_out
);

    localparam logic [CW-1:0] DEF_DIV_W = CW'(DEF_DIV);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_div;
    logic [CW-1:0] r_phase;
    logic [CW-1:0] r_sh_div;
    logic [CW-1:0] r_sh_phase;
    logic          r_pend;
    logic          w_wrap;

    assign w_wrap = i_en && (r_cnt == (r_div - CW'(1)));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt      <= '0;
            r_div      <= DEF_DIV_W;
            r_phase    <= '0;
            r_sh_div   <= DEF_DIV_W;
            r_sh_phase <= '0;
            r_pend     <= 1'b0;
        end else if (i_load) begin
            // A write landing with load bypasses the shadow wait entirely.
            r_cnt  <= '0;
            r_pend <= 1'b0;
            if (i_wr) begin
                r_div      <= i_wr_div;
                r_phase    <= i_wr_phase;
                r_sh_div   <= i_wr_div;
                r_sh_phase <= i_wr_phase;
            end else if (r_pend) begin
                r_div   <= r_sh_div;
                r_phase <= r_sh_phase;
            end
        end else begin
            if (i_en) begin
                r_cnt <= w_wrap ? '0 : (r_cnt + CW'(1));
            end
            if (w_wrap && r_pend) begin
                r_div   <= r_sh_div;
                r_phase <= r_sh_phase;
                r_pend  <= 1'b0;
            end
            // Placed last so a write on the wrap edge re-arms pending.
            if (i_wr) begin
                r_sh_div   <= i_wr_div;
                r_sh_phase <= i_wr_phase;
                r_pend     <= 1'b1;
            end
        end
    end

    assign o_pending = r_pend;
    assign o_en_out  = i_en && (r_cnt == r_phase);

`ifdef MULTI_RATE_EN_GEN_DBG_COUNT_EN
    assign o_dbg_cnt = r_cnt;
`endif

endmodule

// File: rtl/multi_rate_en_gen.sv
// Multi-rate enable generator top: config write validation, per-channel
// write steering and the cfg_err pulse. MULTI_RATE_EN_GEN_DBG_COUNT_EN adds dbg_cnt.
module multi_rate_en_gen
    import multi_rate_en_gen_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int CW      = 8,
    parameter int DEF_DIV = DIV_8MHZ,
    localparam int CHW    = ch_sel_width(NCH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic           load,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_div,
    input  logic [CW-1:0]  cfg_phase,
    output logic           cfg_err,
    output logic [NCH-1:0] cfg_pending,
    output logic [NCH-1:0] en_out
`ifdef MULTI_RATE_EN_GEN_DBG_COUNT_EN
    ,
    output logic [NCH*CW-1:0] dbg_cnt
`endif
);

    localparam logic [CHW:0] NCH_L = (CHW+1)'(NCH);

    logic           w_valid;
    logic [NCH-1:0] w_wr_ch;
    logic           r_cfg_err;

    assign w_valid = cfg_we
                   && ({1'b0, cfg_ch} < NCH_L)
                   && (cfg_div >= CW'(2))
                   && (cfg_phase < cfg_div);

    always_comb begin
        w_wr_ch = '0;
        for (int i = 0; i < NCH; i++) begin
            w_wr_ch[i] = w_valid && (cfg_ch == CHW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we && !w_valid;
        end
    end

    assign cfg_err = r_cfg_err;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        en_gen_channel #(
            .CW      (CW),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
`ifdef MULTI_RATE_EN_GEN_DBG_COUNT_EN
            .o_dbg_cnt  (dbg_cnt[i*CW +: CW]),
`endif
            .i_clk      (clk),
            .i_reset    (reset),
            .i_en       (en),
            .i_load     (load),
            .i_wr       (w_wr_ch[i]),
            .i_wr_div   (cfg_div),
            .i_wr_phase (cfg_phase),
            .o_pending  (cfg_pending[i]),
            .o_en_out   (en_out[i])
        );
    end

endmodule
